lcd_host_driver: RTL and testbench

Host-side initiator for the 12x9 LCD controller command/data interface. Accepts commands from an upstream sequencer and buffers the 108-pixel image for LOAD. Issues each command to the controller with the required one-cycle strobe, streams image bytes back-to-back, captures the 16 returned display pixels, and reports them with a running checksum. Sits between the test or firmware command source and the LCD controller instance.

---
 rtl/lcd_host_driver.sv | 193 +++++++++++++++++++
 tb/tb_lcd_host_driver.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_host_driver.sv
`timescale 1ns/1ps
// lcd_host_driver
// Host-side initiator for the 12x9 LCD controller. Accepts one command at a
// time from an upstream sequencer, buffers the 108-byte image for LOAD,
// strobes the command to the controller, streams the image back-to-back,
// captures the 16 returned display pixels and reports them with their sum.
//
// Optional feature macro: LCD_HOST_DRIVER_TIMEOUT_EN adds an 8-bit watchdog
// over ISSUE (busy stuck) and COLLECT (pixels stop arriving).
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_cmd/valid/ready   command request (0 LOAD, 1..8 ops, 9..15 invalid)
//   pix_data/valid/ready  image bytes for LOAD
//   cmd, cmd_valid        command to controller, one-cycle strobe
//   datain                image byte to controller (0 when not streaming)
//   busy                  controller busy
//   dataout, output_valid controller display pixel
//   res_pixel/valid/last  captured pixel, one cycle per pixel, last on 16th
//   res_sum               sum of the 16 pixels, updated when done pulses
//   done, err             completion pulse, invalid-code (or timeout) pulse
//
// Handshakes: a transfer happens in a cycle where valid and ready are both
// 1 at the rising edge; ready never depends combinationally on valid.
module lcd_host_driver #(
  parameter int IMG_PIX = 108,
  parameter int OUT_PIX = 16
`ifdef LCD_HOST_DRIVER_TIMEOUT_EN
  , parameter int TO_CYC = 255
`endif
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req_cmd,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] pix_data,
  input  logic       pix_valid,
  output logic       pix_ready,
  output logic [3:0] cmd,
  output logic       cmd_valid,
  output logic [7:0] datain,
  input  logic       busy,
  input  logic [7:0] dataout,
  input  logic       output_valid,
  output logic [7:0] res_pixel,
  output logic       res_valid,
  output logic       res_last,
  output logic [11:0] res_sum,
  output logic       done,
  output logic       err
);

  localparam int IW = $clog2(IMG_PIX);
  localparam int CW = $clog2(OUT_PIX);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_ISSUE, S_STREAM, S_COLLECT, S_DONE
  } state_t;

  state_t          state, next_state;
  logic [3:0]      code_q;
  logic [IW-1:0]   wr_idx, rd_idx;
  logic [CW-1:0]   pix_cnt;
  logic [11:0]     acc;
  logic [7:0]      pix_buf [IMG_PIX];

  logic req_acc, pix_acc, fire, bad_code, timeout, last_pix;

  assign req_acc  = (state == S_IDLE) && req_valid && req_ready;
  assign pix_acc  = (state == S_FILL) && pix_valid && pix_ready;
  assign last_pix = (state == S_COLLECT) && output_valid &&
                    (pix_cnt == CW'(OUT_PIX - 1));

`ifdef LCD_HOST_DRIVER_TIMEOUT_EN
  logic [7:0] wd;
  // Counts cycles spent stalled in ISSUE or waiting for pixels in COLLECT.
  assign timeout = (wd == 8'(TO_CYC - 1)) &&
                   (((state == S_ISSUE) && busy) ||
                    ((state == S_COLLECT) && !output_valid));

  always_ff @(posedge clk) begin
    if (reset) wd <= '0;
    else if (fire || ((state != S_ISSUE) && (state != S_COLLECT)) ||
             ((state == S_COLLECT) && output_valid) || timeout)
      wd <= '0;
    else
      wd <= wd + 8'd1;
  end
`else
  assign timeout = 1'b0;
`endif

  // The strobe is registered, so it is decided at the edge that samples
  // busy=0; from IDLE/FILL that lets cmd_valid appear the very next cycle.
  always_comb begin
    next_state = state;
    fire       = 1'b0;
    bad_code   = 1'b0;
    case (state)
      S_IDLE: if (req_acc) begin
        if (req_cmd == 4'd0) next_state = S_FILL;
        else if (req_cmd <= 4'd8) begin
          if (!busy) begin
            fire       = 1'b1;
            next_state = S_COLLECT;
          end else next_state = S_ISSUE;
        end else bad_code = 1'b1;
      end
      S_FILL: if (pix_acc && (wr_idx == IW'(IMG_PIX - 1))) begin
        if (!busy) begin
          fire       = 1'b1;
          next_state = S_STREAM;
        end else next_state = S_ISSUE;
      end
      S_ISSUE: begin
        if (!busy) begin
          fire       = 1'b1;
          next_state = (code_q == 4'd0) ? S_STREAM : S_COLLECT;
        end else if (timeout) next_state = S_IDLE;
      end
      S_STREAM:  if (rd_idx == IW'(IMG_PIX - 1)) next_state = S_COLLECT;
      S_COLLECT: begin
        if (last_pix) next_state = S_DONE;
        else if (timeout) next_state = S_IDLE;
      end
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Image buffer has no reset; its contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (pix_acc) pix_buf[wr_idx] <= pix_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready <= 1'b0;
      pix_ready <= 1'b0;
      cmd       <= '0;
      cmd_valid <= 1'b0;
      datain    <= '0;
      res_pixel <= '0;
      res_valid <= 1'b0;
      res_last  <= 1'b0;
      res_sum   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      code_q    <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      pix_cnt   <= '0;
      acc       <= '0;
    end else begin
      req_ready <= (next_state == S_IDLE);
      pix_ready <= (next_state == S_FILL);
      cmd_valid <= fire;
      if (fire) cmd <= (state == S_IDLE) ? req_cmd : code_q;
      if (req_acc) code_q <= req_cmd;

      wr_idx <= (state == S_FILL) ? (pix_acc ? wr_idx + IW'(1) : wr_idx) : '0;
      rd_idx <= (state == S_STREAM) ? rd_idx + IW'(1) : '0;
      datain <= (state == S_STREAM) ? pix_buf[rd_idx] : 8'd0;

      res_valid <= (state == S_COLLECT) && output_valid;
      res_last  <= last_pix;
      if ((state == S_COLLECT) && output_valid) res_pixel <= dataout;

      if (state == S_COLLECT) begin
        if (output_valid) begin
          pix_cnt <= pix_cnt + CW'(1);
          acc     <= acc + {4'd0, dataout};
        end
      end else begin
        pix_cnt <= '0;
        // Cleared before the strobe so each command sums only its own pixels.
        if ((state == S_IDLE) || (state == S_FILL) || (state == S_ISSUE))
          acc <= '0;
      end

      done <= (state == S_DONE) || timeout;
      err  <= bad_code || timeout;
      if ((state == S_DONE) || timeout) res_sum <= acc;
    end
  end

endmodule

// File: tb/tb_lcd_host_driver.sv
`timescale 1ns/1ps
module tb_lcd_host_driver;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req_cmd;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic [3:0] cmd;
  logic       cmd_valid;
  logic [7:0] datain;
  logic       busy;
  logic [7:0] dataout;
  logic       output_valid;
  logic [7:0] res_pixel;
  logic       res_valid;
  logic       res_last;
  logic [11:0] res_sum;
  logic       done;
  logic       err;

  int total = 0;
  int bad   = 0;
  int n_res = 0;
  logic [7:0] exp_q[$];

  lcd_host_driver dut (
    .clk(clk), .reset(reset),
    .req_cmd(req_cmd), .req_valid(req_valid), .req_ready(req_ready),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .cmd(cmd), .cmd_valid(cmd_valid), .datain(datain), .busy(busy),
    .dataout(dataout), .output_valid(output_valid),
    .res_pixel(res_pixel), .res_valid(res_valid), .res_last(res_last),
    .res_sum(res_sum), .done(done), .err(err)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL global_timeout act=running req=finished");
    $fatal(1, "simulation time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0d req=%0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard for captured pixels ----------------
  always @(negedge clk) begin
    if (reset) n_res = 0;
    else if (res_valid) begin
      if (exp_q.size() == 0) chk("res_valid_unexpected", 1, 0);
      else chk("res_pixel", {24'd0, res_pixel}, {24'd0, exp_q.pop_front()});
      chk("res_last", {31'd0, res_last}, (n_res == 15) ? 1 : 0);
      n_res = (n_res + 1) % 16;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk_reset_vals();
    chk("rst_req_ready", {31'd0, req_ready}, 0);
    chk("rst_pix_ready", {31'd0, pix_ready}, 0);
    chk("rst_cmd",       {28'd0, cmd}, 0);
    chk("rst_cmd_valid", {31'd0, cmd_valid}, 0);
    chk("rst_datain",    {24'd0, datain}, 0);
    chk("rst_res_pixel", {24'd0, res_pixel}, 0);
    chk("rst_res_valid", {31'd0, res_valid}, 0);
    chk("rst_res_last",  {31'd0, res_last}, 0);
    chk("rst_res_sum",   {20'd0, res_sum}, 0);
    chk("rst_done",      {31'd0, done}, 0);
    chk("rst_err",       {31'd0, err}, 0);
  endtask

  task automatic send_req(input logic [3:0] code);
    int n = 0;
    while (!req_ready && n < 50) begin tick(); n++; end
    chk("req_ready_wait", {31'd0, req_ready}, 1);
    req_cmd = code; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  function automatic logic [7:0] img_byte(input bit inv, input int k);
    return inv ? 8'(255 - k) : 8'(k);
  endfunction

  // LOAD request, 108 bytes, then the strobe one cycle after byte 107.
  task automatic fill_and_strobe(input bit inv);
    send_req(4'd0);
    for (int k = 0; k < 108; k++) begin
      if (k == 0 || k == 107) chk("pix_ready_fill", {31'd0, pix_ready}, 1);
      pix_data = img_byte(inv, k); pix_valid = 1'b1;
      tick();
    end
    pix_valid = 1'b0;
    chk("load_cmd_valid", {31'd0, cmd_valid}, 1);
    chk("load_cmd", {28'd0, cmd}, 0);
    chk("pix_ready_after", {31'd0, pix_ready}, 0);
  endtask

  // Checks datain = buf[k] at F+2+k; returns early after byte stop_at.
  task automatic stream_check(input bit inv, input int stop_at);
    for (int k = 0; k < 108; k++) begin
      tick();
      if (k == 0) chk("cmd_valid_one_cycle", {31'd0, cmd_valid}, 0);
      chk("datain", {24'd0, datain}, {24'd0, img_byte(inv, k)});
      if (k == stop_at) return;
    end
    tick();
    chk("datain_zero_after", {24'd0, datain}, 0);
  endtask

  task automatic drive_pixels(input logic [7:0] base, input logic [7:0] step, input int n);
    for (int i = 0; i < n; i++) begin
      dataout = 8'(base + step * i);
      output_valid = 1'b1;
      exp_q.push_back(dataout);
      tick();
    end
    output_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [11:0] exp_sum);
    int n = 0;
    while (!done && n < 20) begin tick(); n++; end
    chk("done_seen", {31'd0, done}, 1);
    chk("res_sum", {20'd0, res_sum}, {20'd0, exp_sum});
    chk("err_at_done", {31'd0, err}, 0);
    tick();
    chk("done_one_cycle", {31'd0, done}, 0);
    chk("req_ready_after_done", {31'd0, req_ready}, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0]  code;
    int          busy_cyc;
    logic [7:0]  base;
    logic [7:0]  step;
    logic [11:0] exp_sum;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic run_vec(input vec_t v);
    if (v.busy_cyc > 0) busy = 1'b1;
    send_req(v.code);
    if (v.exp_err) begin
      chk("err_pulse", {31'd0, err}, 1);
      chk("err_req_ready", {31'd0, req_ready}, 1);
      chk("err_no_strobe", {31'd0, cmd_valid}, 0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("err_no_done", {31'd0, done}, 0);
        chk("err_no_strobe_late", {31'd0, cmd_valid}, 0);
        chk("err_one_cycle", {31'd0, err}, 0);
      end
      return;
    end
    for (int i = 0; i < v.busy_cyc; i++) begin
      chk("cmd_valid_busy", {31'd0, cmd_valid}, 0);
      tick();
    end
    if (v.busy_cyc > 0) begin busy = 1'b0; tick(); end
    chk("cmd_valid", {31'd0, cmd_valid}, 1);
    chk("cmd", {28'd0, cmd}, {28'd0, v.code});
    tick();
    chk("cmd_valid_single", {31'd0, cmd_valid}, 0);
    drive_pixels(v.base, v.step, 16);
    wait_done(v.exp_sum);
  endtask

  // ---------------- main test ----------------
  initial begin
    // sum = 16*base + step*120 for an arithmetic run of 16 pixels
    vecs[0] = '{4'd4,  0,  8'd13,  8'd3, 12'd568,  1'b0};
    vecs[1] = '{4'd1,  0,  8'd0,   8'd1, 12'd120,  1'b0};
    vecs[2] = '{4'd8,  2,  8'd255, 8'd0, 12'd4080, 1'b0};
    vecs[3] = '{4'd3,  20, 8'd200, 8'd2, 12'd3440, 1'b0};
    vecs[4] = '{4'd12, 0,  8'd0,   8'd0, 12'd0,    1'b1};
    vecs[5] = '{4'd9,  0,  8'd0,   8'd0, 12'd0,    1'b1};
    vecs[6] = '{4'd15, 0,  8'd0,   8'd0, 12'd0,    1'b1};
    vecs[7] = '{4'd5,  0,  8'd7,   8'd5, 12'd712,  1'b0};

    reset = 1'b1; req_cmd = '0; req_valid = 1'b0; pix_data = '0;
    pix_valid = 1'b0; busy = 1'b0; dataout = '0; output_valid = 1'b0;
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk("req_ready_after_reset", {31'd0, req_ready}, 1);

    // stray controller pixel while idle must be ignored
    dataout = 8'hAA; output_valid = 1'b1;
    tick();
    output_valid = 1'b0;
    tick();
    chk("idle_ignore_res_valid", {31'd0, res_valid}, 0);

    // LOAD 0..107, then 16 pixels 1,4,..,46 (sum 376)
    fill_and_strobe(1'b0);
    stream_check(1'b0, -1);
    drive_pixels(8'd1, 8'd3, 16);
    wait_done(12'd376);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // reset while datain shows byte 50, then a fresh LOAD
    fill_and_strobe(1'b0);
    stream_check(1'b0, 50);
    reset = 1'b1;
    tick();
    chk_reset_vals();
    reset = 1'b0;
    exp_q.delete();
    tick();
    chk("req_ready_after_midreset", {31'd0, req_ready}, 1);
    fill_and_strobe(1'b1);
    stream_check(1'b1, -1);
    drive_pixels(8'd100, 8'd7, 16);   // 1600 + 840
    wait_done(12'd2440);

`ifdef LCD_HOST_DRIVER_TIMEOUT_EN
    begin
      int n = 0;
      send_req(4'd2);
      chk("to_cmd_valid", {31'd0, cmd_valid}, 1);
      tick();
      drive_pixels(8'd10, 8'd0, 5);
      while (!done && n < 400) begin tick(); n++; end
      chk("to_done", {31'd0, done}, 1);
      chk("to_idle_cycles", n, 255);
      chk("to_err", {31'd0, err}, 1);
      chk("to_res_sum", {20'd0, res_sum}, 50);
      chk("to_req_ready", {31'd0, req_ready}, 1);
      n_res = 0;
      tick();
    end
`endif

    repeat (3) tick();
    chk("exp_q_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
